// File: rtl/valve_sequencer.sv
// Dripper valve sequencer.
// A request must stay clean for SETTLE_TICKS ticks before the valve opens.
// An open valve is held for at least MIN_ON_TICKS, unless inhibit forces it shut.
// A valve left open for MAX_ON_TICKS goes to LOCKOUT until the request drops.
// Every close is followed by MIN_OFF_TICKS of enforced closed time.
module valve_sequencer #(
    parameter int SETTLE_TICKS  = 4,
    parameter int MIN_ON_TICKS  = 8,
    parameter int MIN_OFF_TICKS = 8,
    parameter int MAX_ON_TICKS  = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       valve_request,
    input  logic       inhibit,
    output logic       valve_open,
    output logic       timeout,
    output logic [2:0] state,
    output logic [7:0] open_events
);

    typedef enum logic [2:0] {
        ST_CLOSED   = 3'b000,
        ST_SETTLING = 3'b001,
        ST_OPEN     = 3'b010,
        ST_HOLD_OFF = 3'b011,
        ST_LOCKOUT  = 3'b100
    } state_t;

    localparam logic [7:0] SETTLE_C  = 8'(SETTLE_TICKS);
    localparam logic [7:0] MIN_ON_C  = 8'(MIN_ON_TICKS);
    localparam logic [7:0] MIN_OFF_C = 8'(MIN_OFF_TICKS);
    localparam logic [7:0] MAX_ON_C  = 8'(MAX_ON_TICKS);

    state_t     state_r;
    state_t     next_state_s;
    logic [7:0] dwell_r;
    logic [7:0] dwell_next_s;
    logic       valve_open_r;
    logic       timeout_r;
    logic [7:0] open_events_r;
    logic       enter_open_s;

    // Next-state decision; the dwell counter compared here is the pre-edge value.
    always_comb begin
        next_state_s = ST_CLOSED;
        case (state_r)
            ST_CLOSED: begin
                if (valve_request && !inhibit) begin
                    next_state_s = ST_SETTLING;
                end else begin
                    next_state_s = ST_CLOSED;
                end
            end
            ST_SETTLING: begin
                if (!valve_request || inhibit) begin
                    next_state_s = ST_CLOSED;
                end else if (dwell_r == SETTLE_C) begin
                    next_state_s = ST_OPEN;
                end else begin
                    next_state_s = ST_SETTLING;
                end
            end
            ST_OPEN: begin
                // inhibit outranks both the timeout and the minimum-on dwell
                if (inhibit) begin
                    next_state_s = ST_HOLD_OFF;
                end else if (dwell_r == MAX_ON_C) begin
                    next_state_s = ST_LOCKOUT;
                end else if (!valve_request && (dwell_r >= MIN_ON_C)) begin
                    next_state_s = ST_HOLD_OFF;
                end else begin
                    next_state_s = ST_OPEN;
                end
            end
            ST_HOLD_OFF: begin
                if (dwell_r == MIN_OFF_C) begin
                    next_state_s = ST_CLOSED;
                end else begin
                    next_state_s = ST_HOLD_OFF;
                end
            end
            ST_LOCKOUT: begin
                if (!valve_request) begin
                    next_state_s = ST_HOLD_OFF;
                end else begin
                    next_state_s = ST_LOCKOUT;
                end
            end
            default: begin
                // unreachable codes recover to a safe closed valve
                next_state_s = ST_CLOSED;
            end
        endcase
    end

    // Dwell counter: zero on any state change (a coincident tick is dropped), else saturating tick count.
    always_comb begin
        dwell_next_s = dwell_r;
        if (next_state_s != state_r) begin
            dwell_next_s = 8'd0;
        end else if (tick && (dwell_r != 8'd255)) begin
            dwell_next_s = dwell_r + 8'd1;
        end else begin
            dwell_next_s = dwell_r;
        end
    end

    // Flags the edge on which the FSM enters OPEN.
    always_comb begin
        enter_open_s = 1'b0;
        if ((next_state_s == ST_OPEN) && (state_r != ST_OPEN)) begin
            enter_open_s = 1'b1;
        end else begin
            enter_open_s = 1'b0;
        end
    end

    // State, dwell and outputs; outputs decode the next state so they track the state register cycle for cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_CLOSED;
            dwell_r       <= 8'd0;
            valve_open_r  <= 1'b0;
            timeout_r     <= 1'b0;
            open_events_r <= 8'd0;
        end else begin
            state_r      <= next_state_s;
            dwell_r      <= dwell_next_s;
            valve_open_r <= (next_state_s == ST_OPEN);
            timeout_r    <= (next_state_s == ST_LOCKOUT);
            if (enter_open_s) begin
                open_events_r <= open_events_r + 8'd1;
            end else begin
                open_events_r <= open_events_r;
            end
        end
    end

    assign valve_open  = valve_open_r;
    assign timeout     = timeout_r;
    assign state       = state_r;
    assign open_events = open_events_r;

endmodule

// File: tb/tb_valve_sequencer.sv
// Self-checking bench for valve_sequencer: a cycle model fills a scoreboard
// queue as stimulus is driven; each entry is popped and compared after the
// edge. Directed checks against hand-derived constants mark key milestones.
module tb_valve_sequencer;

    localparam int SETTLE = 4;
    localparam int MINON  = 8;
    localparam int MINOFF = 8;
    localparam int MAXON  = 60;

    logic       clock;
    logic       reset;
    logic       tick;
    logic       valve_request;
    logic       inhibit;
    logic       valve_open;
    logic       timeout;
    logic [2:0] state;
    logic [7:0] open_events;

    typedef struct {
        logic [2:0] st;
        logic       vo;
        logic       to;
        logic [7:0] ev;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    int m_st  = 0;
    int m_cnt = 0;
    int m_ev  = 0;

    valve_sequencer #(
        .SETTLE_TICKS (SETTLE),
        .MIN_ON_TICKS (MINON),
        .MIN_OFF_TICKS(MINOFF),
        .MAX_ON_TICKS (MAXON)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .valve_request(valve_request),
        .inhibit      (inhibit),
        .valve_open   (valve_open),
        .timeout      (timeout),
        .state        (state),
        .open_events  (open_events)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference behaviour, one call per clock edge.
    task automatic model(input logic r, input logic i, input logic t, input logic rs);
        int nx;
        if (rs) begin
            m_st  = 0;
            m_cnt = 0;
            m_ev  = 0;
        end else begin
            case (m_st)
                0: nx = (r && !i) ? 1 : 0;
                1: nx = (!r || i) ? 0 : ((m_cnt == SETTLE) ? 2 : 1);
                2: begin
                    if (i)                        nx = 3;
                    else if (m_cnt == MAXON)      nx = 4;
                    else if (!r && m_cnt >= MINON) nx = 3;
                    else                          nx = 2;
                end
                3: nx = (m_cnt == MINOFF) ? 0 : 3;
                default: nx = r ? 4 : 3;
            endcase
            if (nx != m_st) m_cnt = 0;
            else if (t && m_cnt < 255) m_cnt = m_cnt + 1;
            if (nx == 2 && m_st != 2) m_ev = (m_ev + 1) % 256;
            m_st = nx;
        end
    endtask

    // One clock cycle: drive, predict, push; then pop and compare after the edge.
    task automatic step(input logic r, input logic i, input logic t, input logic rs);
        exp_t e;
        @(negedge clock);
        valve_request = r;
        inhibit       = i;
        tick          = t;
        reset         = rs;
        model(r, i, t, rs);
        e.st = 3'(m_st);
        e.vo = (m_st == 2);
        e.to = (m_st == 4);
        e.ev = 8'(m_ev);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        chk("sb_state", 32'(state), 32'(e.st));
        chk("sb_valve_open", 32'(valve_open), 32'(e.vo));
        chk("sb_timeout", 32'(timeout), 32'(e.to));
        chk("sb_open_events", 32'(open_events), 32'(e.ev));
    endtask

    // n ticks, each followed by an idle cycle.
    task automatic ticks(input int n, input logic r, input logic i);
        for (int k = 0; k < n; k++) begin
            step(r, i, 1'b1, 1'b0);
            step(r, i, 1'b0, 1'b0);
        end
    endtask

    initial begin
        valve_request = 1'b0;
        inhibit       = 1'b0;
        tick          = 1'b0;
        reset         = 1'b1;

        // reset state
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_valve", 32'(valve_open), 32'd0);
        chk("reset_events", 32'(open_events), 32'd0);

        // clean open
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("clean_settling", 32'(state), 32'd1);
        ticks(3, 1'b1, 1'b0);
        chk("clean_not_yet", 32'(valve_open), 32'd0);
        ticks(1, 1'b1, 1'b0);
        chk("clean_open", 32'(valve_open), 32'd1);
        chk("clean_events", 32'(open_events), 32'd1);

        // minimum on, then re-request ignored during hold-off
        ticks(2, 1'b1, 1'b0);
        ticks(5, 1'b0, 1'b0);
        chk("minon_still_open", 32'(valve_open), 32'd1);
        ticks(1, 1'b0, 1'b0);
        chk("minon_holdoff", 32'(state), 32'd3);
        chk("minon_closed_valve", 32'(valve_open), 32'd0);
        ticks(7, 1'b1, 1'b0);
        chk("holdoff_ignores_req", 32'(state), 32'd3);
        ticks(1, 1'b1, 1'b0);
        chk("holdoff_done", 32'(state), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // glitch reject
        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("glitch_closed", 32'(state), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3, 1'b1, 1'b0);
        chk("glitch_restart", 32'(valve_open), 32'd0);
        ticks(1, 1'b1, 1'b0);
        chk("glitch_open", 32'(valve_open), 32'd1);
        chk("glitch_events", 32'(open_events), 32'd2);

        // inhibit override one tick into OPEN
        ticks(1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("inhibit_valve", 32'(valve_open), 32'd0);
        chk("inhibit_state", 32'(state), 32'd3);
        ticks(8, 1'b0, 1'b0);
        chk("inhibit_closed", 32'(state), 32'd0);

        // timeout and lockout
        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(4, 1'b1, 1'b0);
        ticks(59, 1'b1, 1'b0);
        chk("timeout_still_open", 32'(valve_open), 32'd1);
        ticks(1, 1'b1, 1'b0);
        chk("lockout_state", 32'(state), 32'd4);
        chk("lockout_timeout", 32'(timeout), 32'd1);
        chk("lockout_valve", 32'(valve_open), 32'd0);
        ticks(2, 1'b1, 1'b1);
        chk("lockout_held", 32'(state), 32'd4);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("lockout_release", 32'(state), 32'd3);
        chk("lockout_timeout_clr", 32'(timeout), 32'd0);
        ticks(8, 1'b0, 1'b0);
        chk("lockout_closed", 32'(state), 32'd0);

        // reset mid-OPEN
        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(4, 1'b1, 1'b0);
        chk("pre_reset_events", 32'(open_events), 32'd4);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("rst_open_valve", 32'(valve_open), 32'd0);
        chk("rst_open_state", 32'(state), 32'd0);
        chk("rst_open_events", 32'(open_events), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_reset_eval", 32'(state), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // open_events wrap
        for (int n = 0; n < 256; n++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            ticks(4, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
            ticks(8, 1'b0, 1'b0);
            if (n == 254) chk("events_255", 32'(open_events), 32'd255);
        end
        chk("events_wrap", 32'(open_events), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
